// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/grant/acknowledge bundle between the arbiter and the bus masters.
// Ports (signals):
//   br         [N-1:0]  bus requests, one level per master
//   bg         [N-1:0]  registered one-hot grants (or zero)
//   cntrlr_ack [N-1:0]  per-controller acknowledges
//   bus_ack             OR of all controller acknowledges
//   busy                arbiter holds a granted tenure
//   owner      [W-1:0]  index of the granted master, 0 when nothing is granted
//   preempt             high during the turnaround cycle after a hold timeout
// Modports: master = arbiter side, slave = requester/controller side.
interface bus_arbiter_rr_if #(
    parameter int N = 6
) ();
    localparam int W = $clog2(N);
    logic [N-1:0] br;
    logic [N-1:0] bg;
    logic [N-1:0] cntrlr_ack;
    logic         bus_ack;
    logic         busy;
    logic [W-1:0] owner;
    logic         preempt;
    modport master (input br, cntrlr_ack, output bg, bus_ack, busy, owner, preempt);
    modport slave (output br, cntrlr_ack, input bg, bus_ack, busy, owner, preempt);
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-way bus arbiter, fixed priority or round-robin, with optional hold timeout.
// Ports:
//   clk    bus clock, all state on the rising edge
//   rst_n  asynchronous reset, active-low
//   bus    bus_arbiter_rr_if.master (br, cntrlr_ack in; bg, bus_ack, busy, owner, preempt out)
// Parameters: N requesters, RR_MODE (0 fixed/highest index, 1 round-robin),
//   MAX_HOLD (busy cycles before pre-emption, 0 = unlimited), CNT_W tenure counter width.
module bus_arbiter_rr #(
    parameter int N        = 6,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 8
) (
    input logic            clk,
    input logic            rst_n,
    bus_arbiter_rr_if.master bus
);
    localparam int W = $clog2(N);

    typedef enum logic [2:0] {IDLE = 3'b001, BUSY = 3'b010, TURN = 3'b100} state_t;

    state_t           state, state_n;
    logic [N-1:0]     bg_q, bg_n;
    logic [W-1:0]     ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N-1:0]     ptr_oh, others;
    logic [W-1:0]     win_all, win_oth;
    logic             own_req, timeout;

    // Scans in ascending priority so the last hit wins: index 0..N-1 for fixed
    // priority, ptr+N down to ptr+1 (mod N) for round-robin so ptr+1 wins.
    function automatic logic [W-1:0] pick(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] w;
        int j;
        w = '0;
        for (int k = N; k >= 1; k--) begin
            j = (RR_MODE != 0) ? (int'(p) + k) % N : N - k;
            if (r[j[W-1:0]]) w = j[W-1:0];
        end
        return w;
    endfunction

    // ptr is the last granted master, so it is also the current owner in BUSY
    // and the pre-empted master in TURN.
    assign ptr_oh  = N'(1) << ptr;
    assign others  = bus.br & ~ptr_oh;
    assign own_req = |(bus.br & ptr_oh);
    assign win_all = pick(bus.br, ptr);
    assign win_oth = pick(others, ptr);
    assign timeout = (MAX_HOLD > 0) && (cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_n = state;
        bg_n    = bg_q;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: if (|bus.br) begin
                state_n = BUSY;
                bg_n    = N'(1) << win_all;
                ptr_n   = win_all;
                cnt_n   = '0;
            end
            BUSY: if (!own_req && |others) begin
                bg_n    = N'(1) << win_oth;
                ptr_n   = win_oth;
                cnt_n   = '0;
            end else if (!own_req) begin
                state_n = IDLE;
                bg_n    = '0;
            end else if (timeout && |others) begin
                state_n = TURN;
                bg_n    = '0;
            end else begin
                cnt_n   = &cnt ? cnt : cnt + CNT_W'(1);
            end
            TURN: if (|others) begin
                state_n = BUSY;
                bg_n    = N'(1) << win_oth;
                ptr_n   = win_oth;
                cnt_n   = '0;
            end else if (own_req) begin
                state_n = BUSY;
                bg_n    = ptr_oh;
                cnt_n   = '0;
            end else begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                bg_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bg_q  <= '0;
            ptr   <= W'(N - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            bg_q  <= bg_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.bg      = bg_q;
    assign bus.owner   = |bg_q ? ptr : '0;
    assign bus.busy    = state == BUSY;
    assign bus.preempt = state == TURN;
    assign bus.bus_ack = |bus.cntrlr_ack;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed bench for bus_arbiter_rr in fixed, round-robin and timeout builds.
module tb_bus_arbiter_rr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bus_arbiter_rr_if #(.N(6)) if0 ();
    bus_arbiter_rr_if #(.N(6)) if1 ();
    bus_arbiter_rr_if #(.N(6)) if2 ();

    bus_arbiter_rr #(.N(6), .RR_MODE(0), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bus_arbiter_rr #(.N(6), .RR_MODE(1), .MAX_HOLD(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bus_arbiter_rr #(.N(6), .RR_MODE(0), .MAX_HOLD(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] e;
        clk = 0;
        rst_n = 0;
        checks = 0;
        errors = 0;
        if0.br = 6'h3F; if0.cntrlr_ack = '0;
        if1.br = '0;    if1.cntrlr_ack = '0;
        if2.br = '0;    if2.cntrlr_ack = '0;
        step();
        step();
        check("rst_bg", if0.bg, 6'h00);
        check("rst_busy", if0.busy, 0);
        check("rst_owner", if0.owner, 0);
        check("rst_preempt", if0.preempt, 0);
        rst_n = 1;
        step();
        check("first_bg", if0.bg, 6'h20);
        check("first_owner", if0.owner, 5);
        check("first_busy", if0.busy, 1);

        if0.br = 6'h00;
        step();
        check("release_bg", if0.bg, 6'h00);
        if0.br = 6'h05;
        step();
        check("fixed_bg", if0.bg, 6'h04);
        check("fixed_owner", if0.owner, 2);
        if0.br = 6'h01;
        step();
        check("handoff_bg", if0.bg, 6'h01);
        check("handoff_busy", if0.busy, 1);
        if0.br = 6'h00;
        step();
        check("idle_bg", if0.bg, 6'h00);
        check("idle_busy", if0.busy, 0);

        // Park the round-robin pointer on 4 so the 3F sweep starts at 5.
        if1.br = 6'h10;
        step();
        check("rr_pre_bg", if1.bg, 6'h10);
        if1.br = 6'h00;
        step();
        check("rr_idle_bg", if1.bg, 6'h00);
        if1.br = 6'h3F;
        step();
        check("rr_bg5", if1.bg, 6'h20);
        for (int i = 0; i < 6; i++) begin
            if1.br = 6'h3F & ~if1.bg;
            step();
            e = 6'(1 << i);
            check("rr_bg", if1.bg, e);
        end
        if1.br = 6'h00;
        step();
        check("rr_end_bg", if1.bg, 6'h00);

        if2.br = 6'h02;
        step();
        check("hold_bg0", if2.bg, 6'h02);
        if2.br = 6'h0A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_bg", if2.bg, 6'h02);
            check("hold_preempt", if2.preempt, 0);
        end
        step();
        check("turn_bg", if2.bg, 6'h00);
        check("turn_preempt", if2.preempt, 1);
        check("turn_busy", if2.busy, 0);
        step();
        check("after_turn_bg", if2.bg, 6'h08);
        check("after_turn_owner", if2.owner, 3);
        check("after_turn_preempt", if2.preempt, 0);
        if2.br = 6'h00;
        step();
        check("hold_idle_bg", if2.bg, 6'h00);

        if2.br = 6'h02;
        step();
        if2.br = 6'h0A;
        repeat (4) step();
        check("regrant_turn", if2.preempt, 1);
        if2.br = 6'h02;
        step();
        check("regrant_bg", if2.bg, 6'h02);
        if2.br = 6'h00;
        step();

        if2.br = 6'h02;
        for (int i = 0; i < 20; i++) begin
            step();
            check("sole_bg", if2.bg, 6'h02);
            check("sole_preempt", if2.preempt, 0);
        end
        if2.br = 6'h00;
        step();

        if0.cntrlr_ack = 6'h10;
        #1;
        check("ack_on", if0.bus_ack, 1);
        if0.cntrlr_ack = 6'h00;
        #1;
        check("ack_off", if0.bus_ack, 0);
        if0.br = 6'h01;
        step();
        check("tenure_bg", if0.bg, 6'h01);
        #3 rst_n = 0;
        #1;
        check("async_rst_bg", if0.bg, 6'h00);
        check("async_rst_busy", if0.busy, 0);
        #1 rst_n = 1;
        step();
        check("restart_bg", if0.bg, 6'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
